// File: rtl/data_mem_ctrl_if.sv
// MEM-stage data memory bus: request, store data and registered load response.
// Latency: n/a (signal bundle only).
// Backpressure: none; busy tells the core that requests are currently ignored.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              memRead;
  logic              memWrite;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              busy;
  logic              fault;

  // Core side drives requests and observes the response.
  modport master (
    output memRead, memWrite, funct3, addr, wr_data,
    input  rd_data, rd_valid, busy, fault
  );

  // Memory side.
  modport slave (
    input  memRead, memWrite, funct3, addr, wr_data,
    output rd_data, rd_valid, busy, fault
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed RV32I data memory: sub-word loads/stores, clear sweep, fault reporting.
// Latency: load data and fault 1 cycle after the sampling edge; stores commit at that edge.
// Backpressure: busy high during the post-reset clear sweep, requests ignored; otherwise one request per cycle.
// Optional: DMEM_MISALIGN_TRAP_EN makes misaligned H/HU/W fault instead of being force-aligned.
module data_mem_ctrl #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_ctrl_if.slave bus
);

  localparam int                 IDX_W   = ADDR_W - 2;
  localparam logic [IDX_W:0]     DEPTH_L = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]   LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] clear_ptr;
  logic [31:0]      mem [DEPTH];

  logic             clear_en;
  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] mem_idx;
  logic [1:0]       lane;
  logic             in_range;
  logic             f3_ok;
  logic             misalign;
  logic             legal;
  logic             load_en;
  logic             store_en;
  logic [3:0]       strb;
  logic [31:0]      st_word;
  logic [31:0]      word;
  logic [31:0]      shifted;
  logic [31:0]      ld_val;

  assign bus.busy = (state == CLEAR);

  // State register and sweep pointer; reset restarts the sweep from word 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      clear_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        clear_ptr <= clear_ptr + 1'b1;
      end
    end
  end

  // Next state: sweep until the last word is zeroed, then accept requests.
  always_comb begin
    state_nxt = state;
    clear_en  = 1'b0;
    accept    = 1'b0;
    case (state)
      CLEAR: begin
        clear_en = !reset;
        if (clear_ptr == LAST) begin
          state_nxt = READY;
        end
      end
      READY: begin
        accept = bus.memRead | bus.memWrite;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Request decode: legality, effective lane, store strobes and load extraction.
  always_comb begin
    idx      = bus.addr[ADDR_W-1:2];
    lane     = bus.addr[1:0];
    in_range = ({1'b0, idx} < DEPTH_L);
    misalign = 1'b0;

    case (bus.funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      // Unsigned widths only exist for loads.
      3'b100, 3'b101:         f3_ok = !bus.memWrite;
      default:                f3_ok = 1'b0;
    endcase

`ifdef DMEM_MISALIGN_TRAP_EN
    case (bus.funct3[1:0])
      2'b01:   misalign = lane[0];
      2'b10:   misalign = |lane;
      default: misalign = 1'b0;
    endcase
`else
    // Misaligned halves/words are silently aligned down.
    case (bus.funct3[1:0])
      2'b01:   lane[0] = 1'b0;
      2'b10:   lane    = 2'b00;
      default: lane    = lane;
    endcase
`endif

    legal = f3_ok & in_range & !misalign;

    case (bus.funct3[1:0])
      2'b00: begin
        strb    = 4'b0001 << lane;
        st_word = {4{bus.wr_data[7:0]}};
      end
      2'b01: begin
        strb    = lane[1] ? 4'b1100 : 4'b0011;
        st_word = {2{bus.wr_data[15:0]}};
      end
      default: begin
        strb    = 4'b1111;
        st_word = bus.wr_data;
      end
    endcase

    // Out-of-range index never reaches the array; the result is discarded anyway.
    mem_idx = in_range ? idx : '0;
    word    = mem[mem_idx];
    shifted = word >> {lane, 3'b000};

    case (bus.funct3)
      3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_val = {24'h0, shifted[7:0]};
      3'b101:  ld_val = {16'h0, shifted[15:0]};
      default: ld_val = shifted;
    endcase

    load_en  = accept & bus.memRead;
    store_en = accept & bus.memWrite & legal;
  end

  // Array write port: sweep zeroing or strobed store. The load path above sees the
  // pre-edge word, which gives read-before-write for a simultaneous load/store.
  always_ff @(posedge clk) begin
    if (clear_en) begin
      mem[clear_ptr] <= 32'h0;
    end else if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          mem[idx][b*8 +: 8] <= st_word[b*8 +: 8];
        end
      end
    end
  end

  // Registered response: one-cycle valid/fault pulses, data zero when not valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rd_data  <= 32'h0;
      bus.rd_valid <= 1'b0;
      bus.fault    <= 1'b0;
    end else begin
      bus.rd_valid <= load_en;
      bus.rd_data  <= (load_en && legal) ? ld_val : 32'h0;
      bus.fault    <= accept & !legal;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed test-plan cases plus random traffic against a byte-array model.
// Main DUT has DEPTH=128; a DEPTH=5 DUT covers out-of-range word indices.
// Honours DMEM_MISALIGN_TRAP_EN the same way the design does.
module tb_data_mem_ctrl;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] ref_mem [DEPTH*4];

  data_mem_ctrl_if #(.ADDR_W(9)) bus1 ();
  data_mem_ctrl_if #(.ADDR_W(5)) bus2 ();

  data_mem_ctrl #(.DEPTH(DEPTH)) u_dut  (.clk(clk), .reset(reset), .bus(bus1));
  data_mem_ctrl #(.DEPTH(5))     u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: byte-granular memory, access size from funct3, legality from the rules.
  task automatic model(input bit rd, input bit wr, input logic [2:0] f3, input int a_in,
                       input logic [31:0] wd, output bit ev, output logic [31:0] ed,
                       output bit ef);
    int size;
    int a;
    bit bad;
    logic [31:0] v;
    logic [31:0] mask;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    a    = a_in;
    bad  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && (f3 == 3'd4 || f3 == 3'd5));
    if ((a / 4) >= DEPTH) bad = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((a % size) != 0) bad = 1'b1;
`else
    a = a - (a % size);
`endif
    ef = (rd || wr) && bad;
    ev = rd;
    ed = 32'h0;
    if (rd && !bad) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*size)) - 32'h1);
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      ed = v;
    end
    if (wr && !bad) begin
      for (int i = 0; i < size; i++) ref_mem[a+i] = wd[8*i +: 8];
    end
  endtask

  // One request on the main DUT, driven mid-cycle and checked after the sampling edge.
  task automatic do_req(input bit rd, input bit wr, input logic [2:0] f3, input logic [8:0] a,
                        input logic [31:0] wd, input string tag, output logic [31:0] got);
    bit ev;
    bit ef;
    logic [31:0] ed;
    model(rd, wr, f3, int'(a), wd, ev, ed, ef);
    bus1.memRead  = rd;
    bus1.memWrite = wr;
    bus1.funct3   = f3;
    bus1.addr     = a;
    bus1.wr_data  = wd;
    @(posedge clk);
    #1;
    check({tag, "_vld"}, {31'b0, bus1.rd_valid}, {31'b0, ev});
    check({tag, "_dat"}, bus1.rd_data, ed);
    check({tag, "_flt"}, {31'b0, bus1.fault}, {31'b0, ef});
    got = bus1.rd_data;
    bus1.memRead  = 1'b0;
    bus1.memWrite = 1'b0;
  endtask

  // DEPTH=5 DUT, word accesses with explicit expectations.
  task automatic req2(input bit rd, input bit wr, input logic [4:0] a, input logic [31:0] wd,
                      input bit ev, input logic [31:0] ed, input bit ef, input string tag);
    bus2.memRead  = rd;
    bus2.memWrite = wr;
    bus2.funct3   = 3'b010;
    bus2.addr     = a;
    bus2.wr_data  = wd;
    @(posedge clk);
    #1;
    check({tag, "_vld"}, {31'b0, bus2.rd_valid}, {31'b0, ev});
    check({tag, "_dat"}, bus2.rd_data, ed);
    check({tag, "_flt"}, {31'b0, bus2.fault}, {31'b0, ef});
    bus2.memRead  = 1'b0;
    bus2.memWrite = 1'b0;
  endtask

  // Count edges until busy falls; optionally hold a load+store request during the sweep.
  task automatic run_sweep(input string tag, input bit poke);
    int cnt;
    cnt = 0;
    if (poke) begin
      bus1.memRead  = 1'b1;
      bus1.memWrite = 1'b1;
      bus1.funct3   = 3'b010;
      bus1.addr     = 9'h040;
      bus1.wr_data  = 32'hDEAD_BEEF;
    end
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      if (poke) begin
        check("sweep_req_vld", {31'b0, bus1.rd_valid}, 32'h0);
        check("sweep_req_flt", {31'b0, bus1.fault}, 32'h0);
      end
      if (!bus1.busy || cnt >= 400) break;
    end
    bus1.memRead  = 1'b0;
    bus1.memWrite = 1'b0;
    check(tag, 32'(cnt), 32'(DEPTH));
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
  endtask

  initial begin
    logic [31:0] got;
    logic [2:0]  f3_tab [8];
    int          k;
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [8:0]  a;

    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    reset = 1'b1;
    bus1.memRead = 1'b0; bus1.memWrite = 1'b0; bus1.funct3 = 3'b0; bus1.addr = '0; bus1.wr_data = '0;
    bus2.memRead = 1'b0; bus2.memWrite = 1'b0; bus2.funct3 = 3'b0; bus2.addr = '0; bus2.wr_data = '0;

    // Reset values.
    #2;
    check("rst_busy_async", {31'b0, bus1.busy}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_data",  bus1.rd_data, 32'h0);
    check("rst_rd_valid", {31'b0, bus1.rd_valid}, 32'h0);
    check("rst_fault",    {31'b0, bus1.fault}, 32'h0);
    check("rst_busy",     {31'b0, bus1.busy}, 32'h1);
    check("rst_busy2",    {31'b0, bus2.busy}, 32'h1);

    reset = 1'b0;
    run_sweep("sweep_len", 1'b1);

    // Cleared memory, and the store attempted during the sweep was dropped.
    do_req(1, 0, 3'b010, 9'h004, 0, "lw_clear", got);
    check("lw_clear_const", got, 32'h0);
    do_req(1, 0, 3'b010, 9'h040, 0, "lw_sweep_st", got);
    check("lw_sweep_st_const", got, 32'h0);

    // Sub-word loads, back to back.
    do_req(0, 1, 3'b010, 9'h010, 32'h80FF_7F01, "sw10", got);
    do_req(1, 0, 3'b000, 9'h011, 0, "lb11", got);  check("lb11_const", got, 32'h0000_007F);
    do_req(1, 0, 3'b000, 9'h012, 0, "lb12", got);  check("lb12_const", got, 32'hFFFF_FFFF);
    do_req(1, 0, 3'b100, 9'h013, 0, "lbu13", got); check("lbu13_const", got, 32'h0000_0080);
    do_req(1, 0, 3'b001, 9'h012, 0, "lh12", got);  check("lh12_const", got, 32'hFFFF_80FF);
    do_req(1, 0, 3'b101, 9'h010, 0, "lhu10", got); check("lhu10_const", got, 32'h0000_7F01);

    // Byte-lane merge.
    do_req(0, 1, 3'b010, 9'h020, 32'h1122_3344, "sw20", got);
    do_req(0, 1, 3'b000, 9'h021, 32'h0000_00AA, "sb21", got);
    do_req(0, 1, 3'b001, 9'h022, 32'h0000_BEEF, "sh22", got);
    do_req(1, 0, 3'b010, 9'h020, 0, "lw20", got);  check("lw20_const", got, 32'hBEEF_AA44);

    // Read-before-write on a combined request.
    do_req(0, 1, 3'b010, 9'h030, 32'h9, "sw30_old", got);
    do_req(1, 1, 3'b010, 9'h030, 32'h5, "rw30", got); check("rw30_const", got, 32'h9);
    do_req(1, 0, 3'b010, 9'h030, 0, "lw30", got);     check("lw30_const", got, 32'h5);

    // Bad funct3 and unsigned store.
    do_req(1, 0, 3'b011, 9'h010, 0, "f3_011_ld", got);
    do_req(0, 1, 3'b110, 9'h010, 32'hFFFF_FFFF, "f3_110_st", got);
    do_req(0, 1, 3'b100, 9'h010, 32'hFFFF_FFFF, "sbu_st", got);
    do_req(1, 0, 3'b010, 9'h010, 0, "lw10_intact", got); check("lw10_intact_const", got, 32'h80FF_7F01);

    // Misalignment.
    do_req(0, 1, 3'b010, 9'h004, 32'h1234_5678, "sw04", got);
    do_req(1, 0, 3'b010, 9'h006, 0, "lw06", got);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lw06_const", got, 32'h0);
`else
    check("lw06_const", got, 32'h1234_5678);
`endif
    do_req(0, 1, 3'b010, 9'h006, 32'hFFFF_0000, "sw06", got);
    do_req(1, 0, 3'b010, 9'h004, 0, "lw04", got);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lw04_const", got, 32'h1234_5678);
`else
    check("lw04_const", got, 32'hFFFF_0000);
`endif
    do_req(1, 0, 3'b001, 9'h007, 0, "lh07", got);

    // Out-of-range word index on the small instance.
    req2(1, 0, 5'h14, 32'h0,  1, 32'h0, 1, "r2_oor_ld");
    req2(0, 1, 5'h10, 32'hA5, 0, 32'h0, 0, "r2_st");
    req2(0, 1, 5'h1C, 32'hFF, 0, 32'h0, 1, "r2_oor_st");
    req2(1, 0, 5'h10, 32'h0,  1, 32'hA5, 0, "r2_ld");

    // Random traffic, back to back, including idle cycles and illegal requests.
    for (int n = 0; n < 600; n++) begin
      k  = int'($urandom_range(0, 15));
      rd = $urandom_range(0, 1) == 1;
      wr = $urandom_range(0, 2) == 0;
      f3 = (k < 14) ? f3_tab[k % 5] : f3_tab[5 + int'($urandom_range(0, 2))];
      a  = (k % 4 == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 63));
      do_req(rd, wr, f3, a, $urandom, "rnd", got);
    end

    // Reset in the middle of a sweep.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, bus1.busy}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_sweep("restart_sweep", 1'b0);
    do_req(1, 0, 3'b010, 9'h010, 0, "post_clear", got);
    check("post_clear_const", got, 32'h0);

    // Reset with a load in flight.
    do_req(0, 1, 3'b010, 9'h008, 32'hCAFE_F00D, "sw08", got);
    bus1.memRead = 1'b1;
    bus1.funct3  = 3'b010;
    bus1.addr    = 9'h008;
    @(posedge clk);
    #1;
    bus1.memRead = 1'b0;
    check("inflight_vld", {31'b0, bus1.rd_valid}, 32'h1);
    check("inflight_dat", bus1.rd_data, 32'hCAFE_F00D);
    #2;
    reset = 1'b1;
    #1;
    check("rst_inflight_vld",  {31'b0, bus1.rd_valid}, 32'h0);
    check("rst_inflight_dat",  bus1.rd_data, 32'h0);
    check("rst_inflight_busy", {31'b0, bus1.busy}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_sweep("final_sweep", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
